// File: rtl/counter15.sv
`default_nettype none
// ============================================================================
// Module   : counter15
// Purpose  : 4-bit synchronous presettable binary counter with asynchronous
//            clear, functionally equivalent to a 74LVC161. Counts 0..15 and
//            wraps; a parallel load presets the count; CEP/CET plus TC allow
//            ripple-free cascading into wider counters.
// Ports    :
//   CP   in   1  clock, all synchronous actions on its rising edge
//   CR   in   1  asynchronous active-low clear
//   PE   in   1  active-low synchronous parallel load
//   CEP  in   1  count enable (parallel), active-high
//   CET  in   1  count enable (trickle), active-high, also gates TC
//   D    in   4  parallel load data, D[3] is the MSB
//   Q    out  4  registered counter state
//   TC   out  1  terminal count, combinational
// Revision : 1.0 - initial release
// ============================================================================
module counter15 (
  input  logic       CP,
  input  logic       CR,
  input  logic       PE,
  input  logic       CEP,
  input  logic       CET,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);

  localparam logic [3:0] C_TERMINAL = 4'hF;
  localparam logic [3:0] C_ONE      = 4'h1;

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load beats count; count needs both enables; otherwise hold.
  // The 4-bit add wraps 4'hF to 4'h0 naturally.
  always_comb begin
    count_d = count_q;
    if (!PE) begin
      count_d = D;
    end else if (CEP && CET) begin
      count_d = count_q + C_ONE;
    end
  end

  // Clear acts immediately on the falling edge of CR and holds while low.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      count_q <= 4'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q  = count_q;

  // CET gating lets a cascaded stage see TC only when all lower stages are
  // at terminal count; CEP deliberately plays no part here.
  assign TC = CET & (count_q == C_TERMINAL);

endmodule
`default_nettype wire

// File: tb/tb_counter15.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter15
// Purpose  : Directed self-checking testbench for counter15, including a
//            two-stage cascade built from two further instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter15;

  logic       CP;
  logic       CR;
  logic       PE;
  logic       CEP;
  logic       CET;
  logic [3:0] D;
  logic [3:0] Q;
  logic       TC;

  // cascade stimulus
  logic       c_cr;
  logic       c_pe;
  logic       c_cep;
  logic       c_cet_lo;
  logic [3:0] c_d_lo;
  logic [3:0] c_d_hi;
  logic [3:0] c_q_lo;
  logic [3:0] c_q_hi;
  logic       c_tc_lo;
  logic       c_tc_hi;

  int n_pass;
  int n_total;

  counter15 dut (
    .CP (CP),
    .CR (CR),
    .PE (PE),
    .CEP(CEP),
    .CET(CET),
    .D  (D),
    .Q  (Q),
    .TC (TC)
  );

  counter15 u_lo (
    .CP (CP),
    .CR (c_cr),
    .PE (c_pe),
    .CEP(c_cep),
    .CET(c_cet_lo),
    .D  (c_d_lo),
    .Q  (c_q_lo),
    .TC (c_tc_lo)
  );

  counter15 u_hi (
    .CP (CP),
    .CR (c_cr),
    .PE (c_pe),
    .CEP(c_cep),
    .CET(c_tc_lo),
    .D  (c_d_hi),
    .Q  (c_q_hi),
    .TC (c_tc_hi)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_q;
    CR = 1'b0; PE = 1'b0; CEP = 1'b1; CET = 1'b1; D = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (Q !== 4'h0 || TC !== 1'b0) $display("FAIL reset_hold: Q=%h TC=%b, expected Q=0 TC=0", Q, TC);
      else n_pass++;
    end
    CR = 1'b1;
    tick();
    n_total++;
    if (Q !== 4'h6) $display("FAIL first_load: Q=%h, expected 6", Q);
    else n_pass++;
    PE = 1'b1;
    exp_q = 4'h6;
    // 7,8,...,15,0,1
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_q = exp_q + 4'h1;
      n_total++;
      if (Q !== exp_q || TC !== (exp_q == 4'hF))
        $display("FAIL count_seq: Q=%h TC=%b, expected Q=%h TC=%b", Q, TC, exp_q, (exp_q == 4'hF));
      else n_pass++;
    end
  endtask

  task automatic test_tc();
    PE = 1'b0; D = 4'hE; CEP = 1'b1; CET = 1'b1;
    tick();
    PE = 1'b1;
    n_total++;
    if (Q !== 4'hE || TC !== 1'b0) $display("FAIL tc_at_14: Q=%h TC=%b, expected Q=e TC=0", Q, TC);
    else n_pass++;
    tick();
    n_total++;
    if (Q !== 4'hF || TC !== 1'b1) $display("FAIL tc_at_15: Q=%h TC=%b, expected Q=f TC=1", Q, TC);
    else n_pass++;
    CET = 1'b0;
    #1;
    n_total++;
    if (TC !== 1'b0) $display("FAIL tc_cet_gate: TC=%b, expected 0", TC);
    else n_pass++;
    tick();
    n_total++;
    if (Q !== 4'hF || TC !== 1'b0) $display("FAIL tc_hold15: Q=%h TC=%b, expected Q=f TC=0", Q, TC);
    else n_pass++;
    CET = 1'b1;
    #1;
    n_total++;
    if (TC !== 1'b1) $display("FAIL tc_cet_restore: TC=%b, expected 1", TC);
    else n_pass++;
    tick();
    n_total++;
    if (Q !== 4'h0 || TC !== 1'b0) $display("FAIL tc_wrap: Q=%h TC=%b, expected Q=0 TC=0", Q, TC);
    else n_pass++;
    // load of F with CET high raises TC right after the load edge
    PE = 1'b0; D = 4'hF; CEP = 1'b0;
    tick();
    n_total++;
    if (Q !== 4'hF || TC !== 1'b1) $display("FAIL tc_load_f: Q=%h TC=%b, expected Q=f TC=1", Q, TC);
    else n_pass++;
    PE = 1'b1; CEP = 1'b1;
  endtask

  task automatic test_enable();
    PE = 1'b0; D = 4'h9;
    tick();
    PE = 1'b1; CEP = 1'b0; CET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (Q !== 4'h9) $display("FAIL cep_hold: Q=%h, expected 9", Q);
      else n_pass++;
    end
    CEP = 1'b1; CET = 1'b0;
    tick();
    n_total++;
    if (Q !== 4'h9 || TC !== 1'b0) $display("FAIL cet_hold: Q=%h TC=%b, expected Q=9 TC=0", Q, TC);
    else n_pass++;
    CET = 1'b1;
    tick();
    n_total++;
    if (Q !== 4'hA) $display("FAIL enable_resume: Q=%h, expected a", Q);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    PE = 1'b0; D = 4'h3;
    tick();
    n_total++;
    if (Q !== 4'h3) $display("FAIL load_3: Q=%h, expected 3", Q);
    else n_pass++;
    D = 4'hC; CEP = 1'b1; CET = 1'b1;
    tick();
    n_total++;
    if (Q !== 4'hC) $display("FAIL load_over_count: Q=%h, expected c", Q);
    else n_pass++;
    D = 4'h5; CEP = 1'b0; CET = 1'b0;
    tick();
    n_total++;
    if (Q !== 4'h5) $display("FAIL load_no_enable: Q=%h, expected 5", Q);
    else n_pass++;
    // D changes between edges must not disturb a holding counter
    PE = 1'b1; D = 4'hA;
    #2;
    D = 4'h2;
    tick();
    n_total++;
    if (Q !== 4'h5) $display("FAIL hold_ignores_d: Q=%h, expected 5", Q);
    else n_pass++;
    CEP = 1'b1; CET = 1'b1;
  endtask

  task automatic test_async_clear();
    PE = 1'b0; D = 4'hB;
    tick();
    PE = 1'b1; CEP = 1'b1; CET = 1'b1;
    n_total++;
    if (Q !== 4'hB) $display("FAIL clr_pre: Q=%h, expected b", Q);
    else n_pass++;
    #1;
    CR = 1'b0;
    #1;
    n_total++;
    if (Q !== 4'h0 || TC !== 1'b0) $display("FAIL async_clear: Q=%h TC=%b, expected Q=0 TC=0", Q, TC);
    else n_pass++;
    CR = 1'b1;
    #1;
    n_total++;
    if (Q !== 4'h0) $display("FAIL clear_release: Q=%h, expected 0", Q);
    else n_pass++;
    tick();
    n_total++;
    if (Q !== 4'h1) $display("FAIL clear_resume: Q=%h, expected 1", Q);
    else n_pass++;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h0F; exp_v[1] = 8'h10; exp_v[2] = 8'h11;
    c_cr = 1'b1; c_pe = 1'b0; c_cep = 1'b0; c_cet_lo = 1'b1;
    c_d_lo = 4'hE; c_d_hi = 4'h0;
    tick();
    n_total++;
    if ({c_q_hi, c_q_lo} !== 8'h0E) $display("FAIL cascade_load: Q=%h, expected 0e", {c_q_hi, c_q_lo});
    else n_pass++;
    c_pe = 1'b1; c_cep = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({c_q_hi, c_q_lo} !== exp_v[i])
        $display("FAIL cascade_step: Q=%h, expected %h", {c_q_hi, c_q_lo}, exp_v[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    CR = 1'b0; PE = 1'b1; CEP = 1'b0; CET = 1'b0; D = 4'h0;
    c_cr = 1'b0; c_pe = 1'b1; c_cep = 1'b0; c_cet_lo = 1'b1;
    c_d_lo = 4'h0; c_d_hi = 4'h0;
    #1;
    test_reset();
    test_tc();
    test_enable();
    test_load_priority();
    test_async_clear();
    test_cascade();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
